mcs6530_bus_master: RTL

Bus initiator for the 6530 RRIOT emulation: generates the PHI2 clock, RES, address, RS0, R/W and data-bus cycles a 6502 would present, so the chip can be exercised from the board's FPGA or from a bench. It converts a valid/ready request stream into one 6502 bus cycle per PHI2 period and returns read data. It sits on the far side of the 6530's pins, facing the chip's address, data, R/W, PHI2 and RES inputs.

---
 rtl/mcs6530_bus_master.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mcs6530_bus_master.sv
// mcs6530_bus_master: 6502-style bus initiator for exercising the 6530 RRIOT.
// Turns a valid/ready request stream into one PHI2 bus cycle per request,
// generates PHI2 and RES, and returns read data with a one-clk rsp_valid.
// Optional feature macro: MCS6530_BUSM_IRQ_EN (two-flop irq_n synchronizer).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RESET_HOLD | res_n low, no requests accepted, counting RESET_CYCLES bus cycles
// RUN        | res_n high, one request may be accepted per bus cycle

module mcs6530_bus_master #(
    parameter int PHI1_CYCLES  = 4,
    parameter int PHI2_CYCLES  = 4,
    parameter int RESET_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic       req_rs0,
    input  logic [9:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       phi2,
    output logic       res_n,
    output logic [9:0] a,
    output logic       rs0,
    output logic       r_w,
    output logic       sel,
    output logic [7:0] db_o,
    output logic       db_oe,
    input  logic [7:0] db_i,
    input  logic       irq_n,
    output logic       irq
);

    localparam int PH_MAX = (PHI1_CYCLES > PHI2_CYCLES) ? PHI1_CYCLES : PHI2_CYCLES;
    localparam int PW     = $clog2(PH_MAX);
    localparam int RW     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [PW-1:0] PH1_LOAD = PW'(PHI1_CYCLES - 1);
    localparam logic [PW-1:0] PH2_LOAD = PW'(PHI2_CYCLES - 1);
    localparam logic [RW-1:0] RST_LOAD = RW'(RESET_CYCLES - 1);

    typedef enum logic {
        RESET_HOLD,
        RUN
    } state_t;

    state_t        state;
    logic [PW-1:0] ph_cnt;
    logic [RW-1:0] rst_cnt;
    logic [7:0]    wdata_q;

    logic ph_end;
    logic fall_edge;
    logic rise_edge;
    logic hold_end;
    logic accept;

    // Phase terminal counts; PHI1/PHI2 minimums of 2 keep rise and hold_end apart.
    assign ph_end    = (ph_cnt == '0);
    assign fall_edge = phi2 & ph_end;
    assign rise_edge = ~phi2 & ph_end;
    assign hold_end  = ~phi2 & (ph_cnt == PH1_LOAD);
    assign accept    = req_ready & req_valid;

    // Free-running PHI1/PHI2 phase generator (down-counter per phase).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_cnt <= PH1_LOAD;
            phi2   <= 1'b0;
        end else if (ph_end) begin
            phi2   <= ~phi2;
            ph_cnt <= phi2 ? PH1_LOAD : PH2_LOAD;
        end else begin
            ph_cnt <= ph_cnt - 1'b1;
        end
    end

    // Sequencing FSM plus all registered bus and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RESET_HOLD;
            rst_cnt   <= RST_LOAD;
            res_n     <= 1'b0;
            req_ready <= 1'b0;
            a         <= '0;
            rs0       <= 1'b0;
            r_w       <= 1'b1;
            sel       <= 1'b0;
            wdata_q   <= '0;
            db_o      <= '0;
            db_oe     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            // ready is presented on the last clk of PHI2 so the accept edge is the phi2 fall
            req_ready <= (state == RUN) && phi2 && (ph_cnt == PW'(1));
            rsp_valid <= 1'b0;

            case (state)
                RESET_HOLD: begin
                    if (fall_edge) begin
                        if (rst_cnt == '0) begin
                            state <= RUN;
                            res_n <= 1'b1;
                        end else begin
                            rst_cnt <= rst_cnt - 1'b1;
                        end
                    end
                end
                RUN: begin
                    res_n <= 1'b1;
                end
                default: state <= RESET_HOLD;
            endcase

            if (fall_edge) begin
                // close out the bus cycle that is ending
                rsp_valid <= sel;
                if (sel && r_w) begin
                    rsp_rdata <= db_i;
                end
                // open the next bus cycle
                if (accept) begin
                    a       <= req_addr;
                    rs0     <= req_rs0;
                    r_w     <= ~req_we;
                    sel     <= 1'b1;
                    wdata_q <= req_wdata;
                end else begin
                    rs0 <= 1'b0;
                    r_w <= 1'b1;
                    sel <= 1'b0;
                end
            end

            // db_o is loaded at phi2 rise so the hold clk keeps the old write data
            if (rise_edge) begin
                db_oe <= sel & ~r_w;
                if (sel && !r_w) begin
                    db_o <= wdata_q;
                end
            end else if (hold_end) begin
                db_oe <= 1'b0;
            end
        end
    end

`ifdef MCS6530_BUSM_IRQ_EN
    logic irq_s1;
    logic irq_s2;

    // Two-flop synchronizer for the chip's asynchronous IRQ output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_s1 <= 1'b1;
            irq_s2 <= 1'b1;
        end else begin
            irq_s1 <= irq_n;
            irq_s2 <= irq_s1;
        end
    end

    assign irq = ~irq_s2;
`else
    logic unused_irq_n;
    assign unused_irq_n = irq_n;
    assign irq          = 1'b0;
`endif

endmodule
